// File: rtl/fetch_byte_queue.sv
// ---------------------------------------------------------------------------
// fetch_byte_queue
//
// Instruction-fetch stage between the ICache and the Decoder. It requests
// whole lines from the ICache and appends the useful tail of each line to a
// circular byte queue. The Decoder sees the oldest WINDOW bytes and their
// address. Consumed bytes are retired from the head. A redirect flushes
// everything and restarts fetching at the new address.
//
// Ports
//   clk            core clock
//   reset          synchronous, active-high reset
//   set_rip        redirect pulse: flush queue, refetch from new_rip
//   new_rip        redirect target, valid with set_rip
//   icache_enable  line request, held high until icache_done
//   icache_addr    line-aligned request address, stable while enable is high
//   icache_rdata   line data, byte i at [8*i +: 8]
//   icache_done    one-cycle pulse: rdata valid, request complete
//   decode_bytes   window for the Decoder, byte k (oldest = 0) at [8*k +: 8]
//   decode_rip     address of decode_bytes byte 0
//   bytes_decoded  number of bytes the Decoder retires (1..WINDOW)
//   if_dc          window valid: at least WINDOW bytes are queued
//   dc_if          Decoder consumes bytes_decoded bytes this cycle
// ---------------------------------------------------------------------------
module fetch_byte_queue #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int WINDOW     = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_rip,
  input  logic [63:0]             new_rip,
  output logic                    icache_enable,
  output logic [63:0]             icache_addr,
  input  logic [8*LINE_BYTES-1:0] icache_rdata,
  input  logic                    icache_done,
  output logic [0:8*WINDOW-1]     decode_bytes,
  output logic [63:0]             decode_rip,
  input  logic [7:0]              bytes_decoded,
  output logic                    if_dc,
  input  logic                    dc_if
);

  localparam int PW = $clog2(BUF_BYTES);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t          r_state;
  logic            r_started;
  logic [63:0]     r_fetchAddr;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_buf [BUF_BYTES];

  logic [OW-1:0]   w_offset;
  logic [63:0]     w_lineBase;
  logic [CW-1:0]   w_appendLen;
  logic            w_append;
  logic            w_consume;
  logic [7:0]      w_bufNext [BUF_BYTES];
  logic [PW-1:0]   w_headNext;
  logic [PW-1:0]   w_tailNext;
  logic [CW-1:0]   w_countNext;

  // Only the part of a line from the fetch offset onward is useful; the
  // bytes in front of the offset belong to code before the fetch target.
  // A redirect in the same cycle as done throws the line away, and the
  // Decoder is only allowed to consume while the window is valid.
  assign w_offset    = r_fetchAddr[OW-1:0];
  assign w_lineBase  = {r_fetchAddr[63:OW], OW'(0)};
  assign w_appendLen = CW'(LINE_BYTES) - CW'(w_offset);
  assign w_append    = (r_state == REQ) && icache_done && !set_rip;
  assign w_consume   = dc_if && if_dc && !set_rip;

  // Next contents of the byte store: the appended bytes land at the tail,
  // wrapping around the end of the buffer through the pointer arithmetic.
  // The window is extracted from this next image so that freshly appended
  // bytes are visible in the same cycle they arrive.
  always_comb begin
    w_bufNext = r_buf;
    for (int j = 0; j < LINE_BYTES; j++) begin
      if (w_append && (CW'(j) < w_appendLen)) begin
        w_bufNext[r_tail + PW'(j)] = icache_rdata[8*int'(w_offset + OW'(j)) +: 8];
      end
    end
  end

  // Pointer and occupancy update. Append and consume can happen together;
  // a redirect empties the queue and overrides both.
  always_comb begin
    w_headNext  = r_head;
    w_tailNext  = r_tail;
    w_countNext = r_count;
    if (set_rip) begin
      w_headNext  = '0;
      w_tailNext  = '0;
      w_countNext = '0;
    end else begin
      if (w_append) begin
        w_tailNext  = r_tail + PW'(w_appendLen);
        w_countNext = r_count + w_appendLen;
      end
      if (w_consume) begin
        w_headNext  = r_head + PW'(bytes_decoded);
        w_countNext = w_countNext - CW'(bytes_decoded);
      end
    end
  end

  // Byte store itself; it carries no reset because the count and pointers
  // already say which entries are meaningful.
  always_ff @(posedge clk) begin
    r_buf <= w_bufNext;
  end

  // Fetch FSM plus the registered Decoder-side outputs. A request only
  // starts when a whole line is guaranteed to fit, and never in a cycle
  // with a redirect because the fetch address is about to change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_started     <= 1'b0;
      r_fetchAddr   <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      icache_enable <= 1'b0;
      icache_addr   <= '0;
      if_dc         <= 1'b0;
      decode_rip    <= '0;
      decode_bytes  <= '0;
    end else begin
      r_head  <= w_headNext;
      r_tail  <= w_tailNext;
      r_count <= w_countNext;
      if_dc   <= (w_countNext >= CW'(WINDOW));
      for (int k = 0; k < WINDOW; k++) begin
        decode_bytes[8*k +: 8] <= w_bufNext[w_headNext + PW'(k)];
      end

      if (set_rip) begin
        decode_rip <= new_rip;
      end else if (w_consume) begin
        decode_rip <= decode_rip + 64'(bytes_decoded);
      end

      if (set_rip) begin
        r_started   <= 1'b1;
        r_fetchAddr <= new_rip;
      end

      case (r_state)
        IDLE: begin
          if (!set_rip && r_started && (r_count <= CW'(BUF_BYTES - LINE_BYTES))) begin
            r_state       <= REQ;
            icache_enable <= 1'b1;
            icache_addr   <= w_lineBase;
          end
        end
        REQ: begin
          if (icache_done) begin
            r_state       <= IDLE;
            icache_enable <= 1'b0;
            if (!set_rip) begin
              r_fetchAddr <= w_lineBase + 64'(LINE_BYTES);
            end
          end else if (set_rip) begin
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (icache_done) begin
            r_state       <= IDLE;
            icache_enable <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          icache_enable <= 1'b0;
        end
      endcase
    end
  end

  // Sanity checks: the Decoder must retire between 1 and WINDOW bytes, and
  // the space check before each request keeps the queue from overflowing.
  always_ff @(posedge clk) begin
    if (!reset && dc_if && if_dc) begin
      assert (bytes_decoded != 8'd0 && bytes_decoded <= 8'(WINDOW));
    end
    if (!reset) begin
      assert (r_count <= CW'(BUF_BYTES));
    end
  end

endmodule
